// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 matrix keypad scanner.
//   state_t    : scanner FSM states
//   KEY_LUT    : hex code for each (row, col) position
//   key_decode : row/col index -> 4-bit hex code
//   col_drive  : column index -> one-hot active-low column drive
package keypad_pkg;

  localparam int unsigned KP_ROWS = 4;
  localparam int unsigned KP_COLS = 4;
  localparam int unsigned IDX_W   = 2;
  localparam int unsigned KEY_W   = 4;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } state_t;

  // Row-major key legend as printed on the keypad.
  localparam logic [KEY_W-1:0] KEY_LUT [0:KP_ROWS-1][0:KP_COLS-1] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  function automatic logic [KEY_W-1:0] key_decode(input logic [IDX_W-1:0] row_idx,
                                                  input logic [IDX_W-1:0] col_idx);
    return KEY_LUT[row_idx][col_idx];
  endfunction

  function automatic logic [KP_COLS-1:0] col_drive(input logic [IDX_W-1:0] col_idx);
    return ~(KP_COLS'(1) << col_idx);
  endfunction

endpackage

// File: rtl/keypad_scanner_sync.sv
// Multi-bit 2-FF synchronizer for quasi-static asynchronous inputs.
//   clk, reset_n : clock, synchronous active-low reset
//   d            : asynchronous input bus
//   q            : synchronized output bus (RESET_VAL after reset)
module keypad_scanner_sync #(
  parameter int unsigned       WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner with press/release debounce.
//   clk, reset_n : clock, synchronous active-low reset
//   rows         : keypad rows, active low, asynchronous
//   cols         : one-hot active-low column drive
//   key          : hex code of the last accepted key
//   key_valid    : one-cycle pulse when key updates
//   key_held     : high while the accepted key remains pressed
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_CYCLES    = 1000,
  parameter int unsigned DEBOUNCE_SCANS = 20
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [KP_ROWS-1:0] rows,
  output logic [KP_COLS-1:0] cols,
  output logic [KEY_W-1:0]   key,
  output logic               key_valid,
  output logic               key_held
);

  localparam int unsigned DWELL_W = (SCAN_CYCLES > 2) ? $clog2(SCAN_CYCLES) : 1;
  localparam int unsigned DB_W    = $clog2(DEBOUNCE_SCANS + 1);

  logic [KP_ROWS-1:0] rows_s;

  state_t             state,     state_nxt;
  logic [DWELL_W-1:0] dwell_cnt;
  logic [IDX_W-1:0]   col_idx,   col_idx_nxt;
  logic [IDX_W-1:0]   row_idx,   row_idx_nxt;
  logic [DB_W-1:0]    db_cnt,    db_cnt_nxt;
  logic [KEY_W-1:0]   key_nxt;
  logic               key_valid_nxt;
  logic               key_held_nxt;

  logic               sample_pt;
  logic               any_low;
  logic [IDX_W-1:0]   low_row;
  logic               cap_low;
  logic               db_last;

  keypad_scanner_sync #(
    .WIDTH     (KP_ROWS),
    .RESET_VAL ({KP_ROWS{1'b1}})
  ) u_row_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (rows),
    .q       (rows_s)
  );

  // Free-running dwell counter; the last count of each dwell is the sample point.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dwell_cnt <= '0;
    end else if (dwell_cnt == DWELL_W'(SCAN_CYCLES - 1)) begin
      dwell_cnt <= '0;
    end else begin
      dwell_cnt <= dwell_cnt + DWELL_W'(1);
    end
  end

  assign sample_pt = (dwell_cnt == DWELL_W'(SCAN_CYCLES - 1));
  assign any_low   = ~&rows_s;
  assign cap_low   = ~rows_s[row_idx];
  assign db_last   = (db_cnt == DB_W'(DEBOUNCE_SCANS - 1));

  // Lowest-numbered low row wins when several rows are pulled down.
  always_comb begin
    low_row = '0;
    for (int i = int'(KP_ROWS) - 1; i >= 0; i--) begin
      if (!rows_s[i]) begin
        low_row = IDX_W'(i);
      end
    end
  end

  // FSM state and datapath registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= SCAN;
      col_idx   <= '0;
      row_idx   <= '0;
      db_cnt    <= '0;
      cols      <= col_drive(IDX_W'(0));
      key       <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state     <= state_nxt;
      col_idx   <= col_idx_nxt;
      row_idx   <= row_idx_nxt;
      db_cnt    <= db_cnt_nxt;
      cols      <= col_drive(col_idx_nxt);
      key       <= key_nxt;
      key_valid <= key_valid_nxt;
      key_held  <= key_held_nxt;
    end
  end

  // Next-state and output logic; rows are only evaluated at sample points.
  always_comb begin
    state_nxt     = state;
    col_idx_nxt   = col_idx;
    row_idx_nxt   = row_idx;
    db_cnt_nxt    = db_cnt;
    key_nxt       = key;
    key_valid_nxt = 1'b0;
    key_held_nxt  = key_held;

    case (state)
      SCAN: begin
        key_held_nxt = 1'b0;
        if (sample_pt) begin
          if (any_low) begin
            row_idx_nxt = low_row;
            if (DEBOUNCE_SCANS == 1) begin
              key_nxt       = key_decode(low_row, col_idx);
              key_valid_nxt = 1'b1;
              key_held_nxt  = 1'b1;
              db_cnt_nxt    = '0;
              state_nxt     = HELD;
            end else begin
              db_cnt_nxt = DB_W'(1);
              state_nxt  = PRESS_DB;
            end
          end else begin
            col_idx_nxt = col_idx + IDX_W'(1);
          end
        end
      end

      PRESS_DB: begin
        if (sample_pt) begin
          if (cap_low) begin
            if (db_last) begin
              key_nxt       = key_decode(row_idx, col_idx);
              key_valid_nxt = 1'b1;
              key_held_nxt  = 1'b1;
              db_cnt_nxt    = '0;
              state_nxt     = HELD;
            end else begin
              db_cnt_nxt = db_cnt + DB_W'(1);
            end
          end else begin
            // Bounce: drop the candidate and move on to the next column.
            db_cnt_nxt  = '0;
            col_idx_nxt = col_idx + IDX_W'(1);
            state_nxt   = SCAN;
          end
        end
      end

      HELD: begin
        key_held_nxt = 1'b1;
        if (sample_pt && !cap_low) begin
          if (DEBOUNCE_SCANS == 1) begin
            key_held_nxt = 1'b0;
            db_cnt_nxt   = '0;
            col_idx_nxt  = col_idx + IDX_W'(1);
            state_nxt    = SCAN;
          end else begin
            db_cnt_nxt = DB_W'(1);
            state_nxt  = REL_DB;
          end
        end
      end

      REL_DB: begin
        key_held_nxt = 1'b1;
        if (sample_pt) begin
          if (!cap_low) begin
            if (db_last) begin
              key_held_nxt = 1'b0;
              db_cnt_nxt   = '0;
              col_idx_nxt  = col_idx + IDX_W'(1);
              state_nxt    = SCAN;
            end else begin
              db_cnt_nxt = db_cnt + DB_W'(1);
            end
          end else begin
            // Release glitch: key is still down, no new pulse.
            db_cnt_nxt = '0;
            state_nxt  = HELD;
          end
        end
      end

      default: begin
        state_nxt = SCAN;
      end
    endcase
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed testbench for keypad_scanner with a behavioural 4x4 keypad model.
module tb_keypad_scanner;

  localparam int unsigned SC = 4;
  localparam int unsigned DB = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  rows;
  logic [3:0]  cols;
  logic [3:0]  key;
  logic        key_valid;
  logic        key_held;
  logic [15:0] pressed = '0;   // bit r*4+c = key at row r, col c is down

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;
  logic prev_valid = 1'b0;
  int tb_dwell = 0;

  always #5 clk = ~clk;

  keypad_scanner #(
    .SCAN_CYCLES    (SC),
    .DEBOUNCE_SCANS (DB)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rows      (rows),
    .cols      (cols),
    .key       (key),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  // Keypad: a row reads low when a pressed key in that row sits in a driven column.
  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !cols[c]) rows[r] = 1'b0;
      end
    end
  end

  // Reference dwell position, used to align stimulus with sample points.
  always @(posedge clk) begin
    if (!reset_n || tb_dwell == int'(SC) - 1) tb_dwell <= 0;
    else tb_dwell <= tb_dwell + 1;
  end

  // Pulse counter and back-to-back key_valid detector.
  always @(negedge clk) begin
    if (key_valid) begin
      pulse_cnt = pulse_cnt + 1;
      checks = checks + 1;
      if (prev_valid) begin
        errors = errors + 1;
        $display("FAIL key_valid_double: got two consecutive pulses, required single-cycle");
      end
    end
    prev_valid = key_valid;
  end

  typedef struct {
    logic [15:0] mask;
    logic [3:0]  exp_key;
    logic [3:0]  exp_cols;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Park at the negedge just after the next sample-point edge.
  task automatic wait_after_sample();
    do @(negedge clk); while (tb_dwell != 0);
  endtask

  // Wait for cols to newly become tgt, with a cycle budget.
  task automatic wait_cols(input logic [3:0] tgt);
    int n;
    n = 0;
    while (cols == tgt && n < 64) begin @(negedge clk); n++; end
    while (cols != tgt && n < 64) begin @(negedge clk); n++; end
    if (n >= 64) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL wait_cols_timeout: got cols %b required %b", cols, tgt);
    end
  endtask

  initial begin
    vecs[0] = '{16'h0040, 4'h6, 4'b1011};  // r1c2
    vecs[1] = '{16'h0101, 4'h1, 4'b1110};  // r0c0 + r2c0, lowest row wins
    vecs[2] = '{16'h8000, 4'hD, 4'b0111};  // r3c3
    vecs[3] = '{16'h1000, 4'hE, 4'b1110};  // r3c0
    vecs[4] = '{16'h0008, 4'hA, 4'b0111};  // r0c3
    vecs[5] = '{16'h0200, 4'h8, 4'b1101};  // r2c1

    // Reset and idle rotation.
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_cols", 32'(cols), 32'h0E);
    check("rst_key", 32'(key), 32'h0);
    check("rst_valid", 32'(key_valid), 32'h0);
    check("rst_held", 32'(key_held), 32'h0);
    reset_n = 1'b1;
    wait_after_sample(); check("rot_c1", 32'(cols), 32'h0D);
    wait_after_sample(); check("rot_c2", 32'(cols), 32'h0B);
    wait_after_sample(); check("rot_c3", 32'(cols), 32'h07);
    wait_after_sample(); check("rot_c0", 32'(cols), 32'h0E);

    // Clean press of "6": pulse exactly 8 cycles after the first low sample.
    pulse_cnt = 0;
    wait_cols(4'b1101);
    pressed = 16'h0040;
    wait_cols(4'b1011);
    repeat (11) @(negedge clk);
    check("lat_pre", 32'(key_valid), 32'h0);
    @(negedge clk);
    check("lat_valid", 32'(key_valid), 32'h1);
    check("lat_key", 32'(key), 32'h6);
    check("lat_held", 32'(key_held), 32'h1);
    @(negedge clk);
    check("lat_post", 32'(key_valid), 32'h0);
    check("lat_frozen", 32'(cols), 32'h0B);
    pressed = '0;
    wait_after_sample(); check("rel_held1", 32'(key_held), 32'h1);
    wait_after_sample(); check("rel_held2", 32'(key_held), 32'h1);
    wait_after_sample(); check("rel_held3", 32'(key_held), 32'h0);
    check("rel_resume", 32'(cols), 32'h07);
    check("lat_pulses", 32'(pulse_cnt), 32'h1);

    // Table-driven press/release vectors.
    for (int i = 0; i < 6; i++) begin
      pulse_cnt = 0;
      pressed = vecs[i].mask;
      repeat (40) @(negedge clk);
      check($sformatf("vec%0d_pulses", i), 32'(pulse_cnt), 32'h1);
      check($sformatf("vec%0d_key", i), 32'(key), 32'(vecs[i].exp_key));
      check($sformatf("vec%0d_held", i), 32'(key_held), 32'h1);
      check($sformatf("vec%0d_cols", i), 32'(cols), 32'(vecs[i].exp_cols));
      pulse_cnt = 0;
      pressed = '0;
      repeat (40) @(negedge clk);
      check($sformatf("vec%0d_relpulses", i), 32'(pulse_cnt), 32'h0);
      check($sformatf("vec%0d_relheld", i), 32'(key_held), 32'h0);
    end

    // Bounce: r0c0 low for exactly one sample point.
    pulse_cnt = 0;
    wait_cols(4'b1110);
    pressed = 16'h0001;
    wait_after_sample();
    check("bnc_frozen", 32'(cols), 32'h0E);
    pressed = '0;
    wait_after_sample();
    check("bnc_advance", 32'(cols), 32'h0D);
    check("bnc_held", 32'(key_held), 32'h0);
    repeat (20) @(negedge clk);
    check("bnc_pulses", 32'(pulse_cnt), 32'h0);
    check("bnc_key", 32'(key), 32'h8);

    // Release glitch: one low sample in REL_DB returns to HELD silently.
    pulse_cnt = 0;
    pressed = 16'h0040;
    repeat (40) @(negedge clk);
    check("gl_held", 32'(key_held), 32'h1);
    wait_after_sample();
    pressed = '0;
    wait_after_sample();                    // HELD -> REL_DB
    pressed = 16'h0040;
    wait_after_sample();                    // REL_DB -> HELD
    check("gl_back", 32'(key_held), 32'h1);
    wait_after_sample();
    pressed = '0;
    wait_after_sample(); check("gl_rel1", 32'(key_held), 32'h1);
    wait_after_sample(); check("gl_rel2", 32'(key_held), 32'h1);
    wait_after_sample(); check("gl_rel3", 32'(key_held), 32'h0);
    check("gl_resume", 32'(cols), 32'h07);
    check("gl_pulses", 32'(pulse_cnt), 32'h1);

    // Second key while held: "0" only registers after "6" is released.
    pulse_cnt = 0;
    pressed = 16'h0040;
    repeat (40) @(negedge clk);
    check("sk_first", 32'(pulse_cnt), 32'h1);
    pressed = 16'h2040;
    pulse_cnt = 0;
    repeat (20) @(negedge clk);
    check("sk_nopulse", 32'(pulse_cnt), 32'h0);
    check("sk_key6", 32'(key), 32'h6);
    check("sk_frozen", 32'(cols), 32'h0B);
    pressed = 16'h2000;
    repeat (60) @(negedge clk);
    check("sk_pulse0", 32'(pulse_cnt), 32'h1);
    check("sk_key0", 32'(key), 32'h0);
    check("sk_held0", 32'(key_held), 32'h1);
    pressed = '0;
    repeat (40) @(negedge clk);
    check("sk_rel", 32'(key_held), 32'h0);

    // Reset while "6" is held, then re-detection.
    pulse_cnt = 0;
    pressed = 16'h0040;
    repeat (40) @(negedge clk);
    check("rh_held", 32'(key_held), 32'h1);
    reset_n = 1'b0;
    @(negedge clk);
    check("rh_cols", 32'(cols), 32'h0E);
    check("rh_key", 32'(key), 32'h0);
    check("rh_heldr", 32'(key_held), 32'h0);
    check("rh_valid", 32'(key_valid), 32'h0);
    reset_n = 1'b1;
    pulse_cnt = 0;
    repeat (50) @(negedge clk);
    check("rh_repulse", 32'(pulse_cnt), 32'h1);
    check("rh_rekey", 32'(key), 32'h6);
    check("rh_reheld", 32'(key_held), 32'h1);
    pressed = '0;
    repeat (40) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans a 4x4 active-low matrix keypad. Drives one column low at a time and reads back the rows.
- Debounces presses and releases. Registers exactly one key per press and emits a 4-bit hex code with a one-cycle valid strobe.
- Input-side counterpart of the multiplexed dual seven-segment display path: the top level feeds key/key_valid into the digit registers that the display multiplexer shows.

Parameters:
- SCAN_CYCLES, 1000, clk cycles each column is driven before its rows are sampled and the scan advances (>=2).
- DEBOUNCE_SCANS, 20, consecutive matching row samples required to accept a press or a release (>=1).

Ports:
- clk  input  1  system clock
- reset_n  input  1  synchronous reset, active low
- rows  input  4  keypad rows, active low, asynchronous to clk, externally pulled up
- cols  output  4  keypad column drive, one-hot active low
- key  output  4  hex code of last accepted key
- key_valid  output  1  one-cycle pulse when key updates
- key_held  output  1  high while an accepted key is still pressed

Behaviour:
- Clock and reset: one clock clk; reset is synchronous, active low (reset_n). All state updates on posedge clk.
- Reset values: cols=4'b1110 (col 0 active), key=4'h0, key_valid=0, key_held=0, state=SCAN, all counters 0.
- Row synchronizer: rows pass through a 2-FF synchronizer (rows_s); all decisions use rows_s only.
- Dwell counter: counts 0..SCAN_CYCLES-1 and wraps.
  - The "sample point" is the cycle where the counter equals SCAN_CYCLES-1.
  - Rows are evaluated only at sample points.
  - The counter never stops, including when the column is frozen.
- States:
  - SCAN:
    - At a sample point with all rows_s high: advance the column 0->1->2->3->0 (cols 1110->1101->1011->0111->1110).
    - At a sample point with any rows_s bit low: capture the column index and the lowest-numbered low row. Freeze cols, set db_cnt=1, go to PRESS_DB.
    - If DEBOUNCE_SCANS=1, go directly to the accept action instead.
  - PRESS_DB:
    - Captured row low at a sample point: db_cnt++.
    - When db_cnt reaches DEBOUNCE_SCANS: accept the key and go to HELD.
      - Accept action: key gets the decoded code and key_valid=1 for exactly that one cycle.
    - Captured row high at a sample point: discard the press, advance the column, go to SCAN.
  - HELD:
    - key_held=1. The column stays frozen; all other rows and keys are ignored.
    - Captured row high at a sample point: db_cnt=1, go to REL_DB.
  - REL_DB:
    - key_held stays 1.
    - Captured row high at a sample point: db_cnt++. At DEBOUNCE_SCANS, set key_held=0, advance the column, go to SCAN.
    - Captured row low at a sample point: return to HELD. No new key_valid is issued.
- Key decode, rows r0..r3 x cols c0..c3:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E 0 F D
- Outputs:
  - key holds its value until the next accept.
  - key_valid never asserts on two consecutive cycles.
  - No pulse is issued on release.
- Latency: from the first low sample of a clean press to key_valid is (DEBOUNCE_SCANS-1)*SCAN_CYCLES cycles. The first low sample itself lags the pin by the 2-cycle synchronizer plus up to one dwell.
- Boundary conditions:
  - Multiple low rows in the active column: lowest row wins.
  - Simultaneous keys in other columns: ignored until release completes.
  - reset_n low mid-operation (any state): all outputs and state return to reset values on that edge. A pending key_valid is dropped.
  - A dwell counter wrap coinciding with a state change is handled as a normal sample point.

Decomposition:
- keypad_pkg:
  - state_t enum {SCAN, PRESS_DB, HELD, REL_DB}
  - 4x4 key code lookup constant
  - function key_decode(row_idx, col_idx) returning a 4-bit code
- Sub-module synchronizer: 2-FF, parameterized width, instantiated with WIDTH=4 for rows.
- The FSM, counters and column drive stay in keypad_scanner.

Test Plan:
All scenarios use SCAN_CYCLES=4, DEBOUNCE_SCANS=3. The bench keypad model drives row r low iff the pressed key's column is driven low.
- Reset/idle: hold reset_n=0 for 2 cycles, then release with no key pressed.
  - Required: cols=1110, key=0, key_valid=0, key_held=0.
  - cols then rotate every 4 cycles: 1110->1101->1011->0111->1110.
- Clean press: press r1c2 ("6").
  - Required: cols freezes at 1011 and exactly one key_valid pulse with key=4'h6, 8 cycles after the first low sample.
  - key_held=1 until 3 high samples after release, then scanning resumes from 0111.
- Bounce: press r0c0 for a single sample point, then release.
  - Required: no key_valid, key stays at its prior value, scanning resumes.
  - Separately, in REL_DB, glitch low for one sample: required return to HELD with no second pulse.
- Second key while held: hold "6", then also press r3c1 ("0"), then release "6" while keeping "0".
  - Required: no pulse while "6" is held.
  - After release debounce, the scan finds "0": one pulse with key=4'h0.
- Priority: press r0c0 and r2c0 together.
  - Required: key=4'h1 and one pulse.
- Reset mid-HELD: assert reset_n=0 for one cycle while "6" is held.
  - Required: next edge gives cols=1110, key=0, key_held=0.
  - After reset, the still-pressed "6" is re-detected and produces a single fresh pulse.
